// File: rtl/rom_read_sequencer.sv
// Sequential ROM reader: walks addresses 0..LAST_ADDRESS, waits ACCESS_CYCLES per byte,
// and hands each byte to a ready/valid consumer while accumulating a 16-bit checksum.
module rom_read_sequencer #(
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter int unsigned LAST_ADDRESS  = 511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  rom_data,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic [8:0]  address_line,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [15:0] checksum,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] WAIT_LAST = 8'(ACCESS_CYCLES - 1);
  localparam logic [8:0] LAST_ADDR = 9'(LAST_ADDRESS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_OUTPUT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] csum_q, csum_d;
  logic [7:0]  wcnt_q, wcnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      csum_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      csum_q  <= csum_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    csum_d  = csum_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // abort is meaningless here, so start always wins
        if (start) begin
          addr_d  = '0;
          csum_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_OUTPUT: begin
        // abort drops the pending byte without counting it
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (data_ready) begin
          valid_d = 1'b0;
          csum_d  = csum_q + {8'h00, data_q};
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 9'd1;
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_ce_n     = !((state_q == S_SETUP) || (state_q == S_WAIT));
  assign rom_oe_n     = rom_ce_n;
  assign busy         = (state_q == S_SETUP) || (state_q == S_WAIT) || (state_q == S_OUTPUT);
  assign done         = (state_q == S_DONE);
  assign address_line = addr_q;
  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign checksum     = csum_q;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench: full 512-byte pass, short pass, backpressure, abort cases and async reset.
module tb_rom_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, data_ready;
  logic [7:0]  rom_data;
  logic        rom_ce_n, rom_oe_n, data_valid, busy, done;
  logic [8:0]  address_line;
  logic [7:0]  data_out;
  logic [15:0] checksum;

  logic        start_s, abort_s, ready_s;
  logic [7:0]  rom_data_s;
  logic        ce_n_s, oe_n_s, valid_s, busy_s, done_s;
  logic [8:0]  addr_s;
  logic [7:0]  dout_s;
  logic [15:0] csum_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data   = address_line[7:0] ^ 8'h5A;
  assign rom_data_s = addr_s[7:0] ^ 8'h5A;

  rom_read_sequencer #(.ACCESS_CYCLES(4), .LAST_ADDRESS(511)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rom_data(rom_data),
    .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .address_line(address_line),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .checksum(checksum), .busy(busy), .done(done)
  );

  rom_read_sequencer #(.ACCESS_CYCLES(4), .LAST_ADDRESS(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .rom_data(rom_data_s),
    .rom_ce_n(ce_n_s), .rom_oe_n(oe_n_s), .address_line(addr_s),
    .data_out(dout_s), .data_valid(valid_s), .data_ready(ready_s),
    .checksum(csum_s), .busy(busy_s), .done(done_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(address_line), 32'h0);
    chk({tag, "_dout"},  32'(data_out),     32'h0);
    chk({tag, "_valid"}, 32'(data_valid),   32'h0);
    chk({tag, "_csum"},  32'(checksum),     32'h0);
    chk({tag, "_ce"},    32'(rom_ce_n),     32'h1);
    chk({tag, "_oe"},    32'(rom_oe_n),     32'h1);
    chk({tag, "_busy"},  32'(busy),         32'h0);
    chk({tag, "_done"},  32'(done),         32'h0);
  endtask

  initial begin
    int cnt;
    logic [15:0] sum100;

    reset = 1'b0; start = 1'b0; abort = 1'b0; data_ready = 1'b1;
    start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b1;
    #3;
    chk_reset_vals("rst0");
    tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // short pass, LAST_ADDRESS=2: 3 bytes x 6 cycles
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cnt = 0;
    while (!done_s && cnt < 100) begin tick(); cnt++; end
    chk("short_cycles", 32'(cnt),    32'd18);
    chk("short_csum",   32'(csum_s), 32'h010D);
    chk("short_addr",   32'(addr_s), 32'd2);
    chk("short_done",   32'(done_s), 32'h1);
    chk("short_busy",   32'(busy_s), 32'h0);

    // full pass with a start pulse injected mid-pass (must be ignored)
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("setup_busy", 32'(busy),     32'h1);
    chk("setup_ce",   32'(rom_ce_n), 32'h0);
    chk("setup_oe",   32'(rom_oe_n), 32'h0);
    cnt = 0;
    while (!done && cnt < 5000) begin
      tick(); cnt++;
      if (cnt == 1000) start = 1'b1;
      if (cnt == 1001) start = 1'b0;
    end
    chk("full_cycles", 32'(cnt),          32'd3072);
    chk("full_csum",   32'(checksum),     32'hFF00);
    chk("full_addr",   32'(address_line), 32'd511);
    chk("full_ce",     32'(rom_ce_n),     32'h1);

    // DONE holds; abort has no effect there
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick();
    chk("done_hold",      32'(done),     32'h1);
    chk("done_csum_hold", 32'(checksum), 32'hFF00);

    // restart from DONE, then backpressure at address 3
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_csum", 32'(checksum),     32'h0);
    chk("restart_addr", 32'(address_line), 32'h0);
    cnt = 0;
    while (address_line != 9'd3 && cnt < 100) begin tick(); cnt++; end
    data_ready = 1'b0;
    chk("bp_reach3", 32'(address_line), 32'd3);
    cnt = 0;
    while (!data_valid && cnt < 20) begin tick(); cnt++; end
    chk("bp_valid_to", 32'(data_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_dout",  32'(data_out),     32'h59);
      chk("bp_valid", 32'(data_valid),   32'h1);
      chk("bp_addr",  32'(address_line), 32'd3);
      chk("bp_ce",    32'(rom_ce_n),     32'h1);
      tick();
    end
    data_ready = 1'b1;
    tick();
    chk("bp_resume_addr",  32'(address_line), 32'd4);
    chk("bp_resume_csum",  32'(checksum),     32'h0166);
    chk("bp_resume_valid", 32'(data_valid),   32'h0);

    // abort in WAIT at address 100
    cnt = 0;
    while (address_line != 9'd100 && cnt < 1000) begin tick(); cnt++; end
    tick();
    chk("ab_wait_ce", 32'(rom_ce_n), 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sum100 = '0;
    for (int i = 0; i < 100; i++) sum100 += 16'(8'(i) ^ 8'h5A);
    chk("ab_busy",  32'(busy),         32'h0);
    chk("ab_done",  32'(done),         32'h0);
    chk("ab_valid", 32'(data_valid),   32'h0);
    chk("ab_addr",  32'(address_line), 32'd100);
    chk("ab_ce",    32'(rom_ce_n),     32'h1);
    chk("ab_csum",  32'(checksum),     32'(sum100));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_idle_addr", 32'(address_line), 32'd100);
    chk("ab_idle_busy", 32'(busy),         32'h0);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; data_ready = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy),         32'h1);
    chk("sa_addr", 32'(address_line), 32'd0);
    chk("sa_csum", 32'(checksum),     32'h0);

    // abort and data_ready together in OUTPUT: byte not counted
    cnt = 0;
    while (!data_valid && cnt < 20) begin tick(); cnt++; end
    chk("ar_dout", 32'(data_out), 32'h5A);
    abort = 1'b1; data_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("ar_csum",  32'(checksum),     32'h0);
    chk("ar_busy",  32'(busy),         32'h0);
    chk("ar_valid", 32'(data_valid),   32'h0);
    chk("ar_addr",  32'(address_line), 32'd0);

    // async reset between edges while in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (address_line != 9'd2 && cnt < 100) begin tick(); cnt++; end
    tick();
    chk("rst_pre_ce", 32'(rom_ce_n), 32'h0);
    #1 reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    #1 reset = 1'b1;
    repeat (5) tick();
    chk("rst_stay_idle", 32'(busy),         32'h0);
    chk("rst_stay_addr", 32'(address_line), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
